// File: rtl/filter_accel_pkg.sv
// Shared types and default widths for the filter accelerator datapath blocks.
package filter_accel_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_DIVIDEND_W = 18;
    localparam int DIV_DIVISOR_W  = 11;
    localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W + 1);

    // Counter must hold the full step count, not just step count - 1.
    function automatic int div_cnt_w(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/filter_accel_div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor when it fits.
module filter_accel_div_step
    import filter_accel_pkg::*;
#(
    parameter int DW = DIV_DIVISOR_W
) (
    input  logic [DW-1:0] rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] rem_out,
    output logic          q_bit
);

    logic [DW:0] trial;

    // rem_in < divisor, so both the kept and the reduced value fit back into DW bits.
    assign trial   = {rem_in, bit_in};
    assign q_bit   = (trial >= {1'b0, divisor});
    assign rem_out = q_bit ? DW'(trial - {1'b0, divisor}) : DW'(trial);

endmodule

// File: rtl/filter_accel_div_seq.sv
// Sequential signed-by-unsigned restoring divider with valid/ready on both sides.
//   state | meaning
//   IDLE  | in_ready high, waiting for an operation
//   CALC  | one restoring step per cycle; terminal count applies sign fix-up
//   DONE  | result presented, held until out_ready
module filter_accel_div_seq
    import filter_accel_pkg::*;
#(
    parameter int din0_WIDTH = DIV_DIVIDEND_W,
    parameter int din1_WIDTH = DIV_DIVISOR_W
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH:0]   rem,
    output logic                  div_by_zero
);

    localparam int CNT_W = div_cnt_w(din0_WIDTH);
    localparam logic [din0_WIDTH-1:0] QMAX = {1'b0, {(din0_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] QMIN = {1'b1, {(din0_WIDTH-1){1'b0}}};

    div_state_t            state;
    logic [din0_WIDTH-1:0] mag;
    logic [din0_WIDTH-1:0] qreg;
    logic [din1_WIDTH-1:0] dvsr;
    logic [din1_WIDTH-1:0] prem;
    logic [din1_WIDTH-1:0] prem_nxt;
    logic [CNT_W-1:0]      cnt;
    logic                  neg;
    logic                  dz;
    logic                  qbit;
    logic [din0_WIDTH-1:0] din0_mag;
    logic [din1_WIDTH:0]   r_ext;

    // The most negative dividend negates onto itself, which is exactly its unsigned magnitude.
    assign din0_mag = din0[din0_WIDTH-1] ? -din0 : din0;
    assign r_ext    = {1'b0, prem};

    filter_accel_div_step #(
        .DW(din1_WIDTH)
    ) u_step (
        .rem_in (prem),
        .bit_in (mag[din0_WIDTH-1]),
        .divisor(dvsr),
        .rem_out(prem_nxt),
        .q_bit  (qbit)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            mag         <= '0;
            qreg        <= '0;
            dvsr        <= '0;
            prem        <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            dz          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mag      <= din0_mag;
                        dvsr     <= din1;
                        neg      <= din0[din0_WIDTH-1];
                        dz       <= (din1 == '0);
                        // A zero divisor skips the steps and finalises on the next edge.
                        cnt      <= (din1 == '0) ? '0 : CNT_W'(din0_WIDTH);
                        prem     <= '0;
                        qreg     <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == '0) begin
                        if (dz) begin
                            quot        <= neg ? QMIN : QMAX;
                            rem         <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            quot        <= neg ? -qreg : qreg;
                            rem         <= neg ? -r_ext : r_ext;
                            div_by_zero <= 1'b0;
                        end
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        mag  <= {mag[din0_WIDTH-2:0], 1'b0};
                        qreg <= {qreg[din0_WIDTH-2:0], qbit};
                        prem <= prem_nxt;
                        cnt  <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_accel_div_seq.sv
// Randomized self-checking bench for filter_accel_div_seq against an arithmetic reference.
module tb_filter_accel_div_seq;

    logic               ap_clk;
    logic               ap_rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [17:0] din0;
    logic [10:0]        din1;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] quot;
    logic signed [11:0] rem;
    logic               div_by_zero;

    int checks = 0;
    int errors = 0;

    filter_accel_div_seq dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din0       (din0),
        .din1       (din1),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division truncates toward zero and % takes the dividend's sign.
    task automatic model(input logic signed [17:0] a, input logic [10:0] b,
                         output logic signed [17:0] q, output logic signed [11:0] r,
                         output logic dz, output int lat);
        longint la;
        longint lb;
        la = longint'(a);
        lb = longint'(b);
        if (b == 11'd0) begin
            dz  = 1'b1;
            r   = 12'sd0;
            q   = (a < 0) ? -18'sd131072 : 18'sd131071;
            lat = 1;
        end else begin
            dz  = 1'b0;
            q   = 18'(la / lb);
            r   = 12'(la % lb);
            lat = 19;
        end
    endtask

    task automatic do_op(input logic signed [17:0] a, input logic [10:0] b, input int hold);
        logic signed [17:0] eq;
        logic signed [11:0] er;
        logic               ed;
        int                 elat;
        int                 k;
        logic signed [17:0] q_seen;
        logic signed [11:0] r_seen;
        model(a, b, eq, er, ed, elat);
        @(negedge ap_clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        din0     = a;
        din1     = b;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            // Noise on the input side must be ignored while busy.
            in_valid = 1'($urandom_range(0, 1));
            din0     = 18'($urandom);
            din1     = 11'($urandom);
            @(posedge ap_clk);
            #1;
            k++;
            if (!out_valid) chk("in_ready_busy", in_ready, 0);
        end
        chk("latency", k, elat);
        chk("quot", quot, eq);
        chk("rem", rem, er);
        chk("div_by_zero", div_by_zero, ed);
        chk("in_ready_done", in_ready, 0);
        q_seen = quot;
        r_seen = rem;
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            din0     = 18'($urandom);
            @(posedge ap_clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quot", quot, q_seen);
            chk("hold_rem", rem, r_seen);
        end
        @(negedge ap_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic signed [17:0] ra;
        logic [10:0]        rb;
        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot", quot, 0);
        chk("rst_rem", rem, 0);
        chk("rst_dz", div_by_zero, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        do_op(18'sd1000, 11'd7, 0);
        do_op(-18'sd1000, 11'd7, 0);
        do_op(18'sd131071, 11'd2047, 0);
        do_op(-18'sd131072, 11'd1, 0);
        do_op(18'sd500, 11'd0, 0);
        do_op(-18'sd5, 11'd0, 0);
        do_op(18'sd1000, 11'd7, 5);
        do_op(-18'sd131072, 11'd2047, 2);
        do_op(18'sd0, 11'd13, 0);

        // Abort mid-operation and confirm no stale result appears.
        @(negedge ap_clk);
        in_valid = 1'b1;
        din0     = 18'sd1000;
        din1     = 11'd7;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_quot", quot, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (12) begin
            @(posedge ap_clk);
            #1;
            chk("abort_no_result", out_valid, 0);
        end
        do_op(18'sd1000, 11'd7, 0);

        for (int n = 0; n < 30; n++) begin
            ra = 18'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 11'd0 : 11'($urandom);
            do_op(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
